// File: rtl/cacheline_adapter_if.sv
// cacheline_adapter_if: cache-side line port and memory-side burst port of the cacheline adapter
interface cacheline_adapter_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: converts cacheline fills/writebacks into fixed-length memory bursts
module cacheline_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input logic clk,
  input logic rst,
  cacheline_adapter_if.slave bus
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int OB    = $clog2(LINE_W / 8);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [LINE_W-1:0]  r_buf;
  logic [LINE_W-1:0]  r_line;
  logic [31:0]        r_addr;
  logic               r_read;
  logic               r_write;
  logic               r_resp;
  logic [LINE_W-1:0]  w_fill;
  logic [31:0]        w_addr;
  logic               w_last;
  // assembly buffer with the current beat merged in, so line_o can load the full line on the last beat
  always_comb begin
    w_fill = r_buf;
    w_fill[r_cnt*BURST_W +: BURST_W] = bus.burst_i;
  end
  assign w_addr        = {bus.address_i[31:OB], OB'(0)};
  assign w_last        = r_cnt == CW'(BEATS - 1);
  assign bus.line_o    = r_line;
  assign bus.address_o = r_addr;
  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;
  assign bus.resp_o    = r_resp;
  assign bus.burst_o   = r_write ? r_buf[r_cnt*BURST_W +: BURST_W] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_line  <= '0;
      r_addr  <= '0;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.write_i) begin
            r_buf   <= bus.line_i;
            r_addr  <= w_addr;
            r_write <= 1'b1;
            r_state <= WR;
          end else if (bus.read_i) begin
            r_addr  <= w_addr;
            r_read  <= 1'b1;
            r_state <= RD;
          end
        end
        RD: begin
          if (bus.resp_i) begin
            r_buf <= w_fill;
            if (w_last) begin
              r_cnt   <= '0;
              r_line  <= w_fill;
              r_read  <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        WR: begin
          if (bus.resp_i) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_write <= 1'b0;
              r_resp  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_resp  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
